// File: rtl/decscan_pkg.sv
// Shared types and constants for the 3-to-8 decoder scan controller.
package decscan_pkg;

    localparam int NUM_CHAN = 8;
    localparam int IDX_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

endpackage

// File: rtl/decscan_next_chan.sv
// Circular next-channel search: first set mask bit after cur, wrapping round
// to cur itself last. wrapped flags that the chosen channel is not above cur.
module decscan_next_chan
    import decscan_pkg::*;
(
    input  logic [NUM_CHAN-1:0] mask,
    input  logic [IDX_W-1:0]    cur,
    output logic [IDX_W-1:0]    nxt,
    output logic                any,
    output logic                wrapped
);

    // rot[k] is the mask bit of channel cur+k+1 (mod 8)
    logic [NUM_CHAN-1:0] rot;
    logic [IDX_W-1:0]    off;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHAN; gi++) begin : g_rot
            localparam logic [IDX_W-1:0] STEP = IDX_W'(gi + 1);
            logic [IDX_W-1:0] pos;
            assign pos     = cur + STEP;
            assign rot[gi] = mask[pos];
        end
    endgenerate

    always_comb begin
        off = '0;
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

    assign any     = |mask;
    assign nxt     = cur + off + IDX_W'(1);
    assign wrapped = any && (nxt <= cur);

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scans the enabled channels of a 3-to-8 decoder with break-before-make blanking.
// Define DECSCAN_BLANK_EN to insert the enable-low BLANK phase before each channel.
module decoder_scan_ctrl
    import decscan_pkg::*;
#(
    parameter int DWELL_CYCLES = 100,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [NUM_CHAN-1:0] chan_mask,
    output logic                e,
    output logic                a,
    output logic                b,
    output logic                c,
    output logic                busy,
    output logic                wrap
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
`ifdef DECSCAN_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam state_t ENTRY_STATE = BLANK;
`else
    localparam state_t ENTRY_STATE = DRIVE;
`endif

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             e_reg, e_next;
    logic             busy_reg, busy_next;
    logic             wrap_reg, wrap_next;

    logic [IDX_W-1:0] nc_cur, nc_nxt;
    logic             nc_any, nc_wrapped;

    // From IDLE, searching after channel 7 yields the lowest set bit
    assign nc_cur = (state_reg == IDLE) ? IDX_W'(NUM_CHAN - 1) : idx_reg;

    decscan_next_chan u_next_chan (
        .mask    (chan_mask),
        .cur     (nc_cur),
        .nxt     (nc_nxt),
        .any     (nc_any),
        .wrapped (nc_wrapped)
    );

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        wrap_next  = 1'b0;
        if (stop) begin
            state_next = IDLE;
            idx_next   = '0;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && nc_any) begin
                        state_next = ENTRY_STATE;
                        idx_next   = nc_nxt;
                        cnt_next   = '0;
                    end
                end
`ifdef DECSCAN_BLANK_EN
                BLANK: begin
                    if (cnt_reg == BLANK_LAST) begin
                        state_next = DRIVE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
`endif
                DRIVE: begin
                    if (cnt_reg == DWELL_LAST) begin
                        cnt_next = '0;
                        if (nc_any) begin
                            state_next = ENTRY_STATE;
                            idx_next   = nc_nxt;
                            wrap_next  = nc_wrapped;
                        end else begin
                            state_next = IDLE;
                            idx_next   = '0;
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    idx_next   = '0;
                    cnt_next   = '0;
                end
            endcase
        end
        // Outputs are registered from the next state so they track it exactly
        e_next    = (state_next == DRIVE);
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            e_reg     <= 1'b0;
            busy_reg  <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            e_reg     <= e_next;
            busy_reg  <= busy_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign e       = e_reg;
    assign {a, b, c} = idx_reg;
    assign busy    = busy_reg;
    assign wrap    = wrap_reg;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench for decoder_scan_ctrl (DWELL=4, BLANK=2); expected per-cycle
// output vectors {e,a,b,c,busy,wrap} are queued by the stimulus and popped at negedge.
module tb_decoder_scan_ctrl;

    localparam int DW = 4;
`ifdef DECSCAN_BLANK_EN
    localparam int BL = 2;
`else
    localparam int BL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] chan_mask = 8'h00;
    logic       e, a, b, c, busy, wrap;

    int n_tests = 0;
    int n_fail  = 0;

    string      name_q[$];
    logic [5:0] val_q[$];

    decoder_scan_ctrl #(
        .DWELL_CYCLES (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .chan_mask (chan_mask),
        .e         (e),
        .a         (a),
        .b         (b),
        .c         (c),
        .busy      (busy),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got {e,abc,busy,wrap}=%b required %b at %0t", name, got, exp, $time);
        end else begin
            $display("[TB] ok   %s: {e,abc,busy,wrap}=%b at %0t", name, got, $time);
        end
    endtask

    // Monitor: one comparison per cycle while expectations are pending
    always @(negedge clk) begin
        if (val_q.size() > 0) begin
            check(name_q.pop_front(), {e, a, b, c, busy, wrap}, val_q.pop_front());
        end
    end

    task automatic exp_seg(input string name, input logic ev, input logic [2:0] idx,
                           input logic bz, input logic wr, input int len);
        for (int i = 0; i < len; i++) begin
            name_q.push_back(name);
            val_q.push_back({ev, idx, bz, (i == 0) ? wr : 1'b0});
        end
    endtask

    // One full channel visit: BL blank cycles then DW drive cycles; wrap on its first cycle
    task automatic exp_chan(input string name, input logic [2:0] idx, input logic wr);
        exp_seg({name, "_blank"}, 1'b0, idx, 1'b1, wr, BL);
        exp_seg({name, "_drive"}, 1'b1, idx, 1'b1, (BL == 0) ? wr : 1'b0, DW);
    endtask

    task automatic exp_idle(input string name, input int n);
        exp_seg(name, 1'b0, 3'd0, 1'b0, 1'b0, n);
    endtask

    // Waits until every queued expectation has been checked; ends at negedge+1
    task automatic drain();
        int budget = 2000;
        do begin
            @(negedge clk);
            #1;
            budget--;
        end while (val_q.size() > 0 && budget > 0);
        if (val_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL drain_timeout: got %0d pending required 0", val_q.size());
            name_q.delete();
            val_q.delete();
        end
    endtask

    task automatic pulse_start(input logic [7:0] m);
        chan_mask = m;
        start     = 1'b1;
    endtask

    task automatic release_start();
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic do_stop(input string name);
        stop = 1'b1;
        exp_idle(name, 2);
        release_start();
        drain();
    endtask

    initial begin
        // Reset state while rst_n is low
        #3;
        check("reset_hold", {e, a, b, c, busy, wrap}, 6'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        exp_idle("post_reset_idle", 3);
        drain();

        // Full scan, two periods, wrap only on 7->0
        pulse_start(8'hFF);
        for (int p = 0; p < 2; p++) begin
            for (int ch = 0; ch < 8; ch++) begin
                exp_chan($sformatf("full_p%0d_ch%0d", p, ch), 3'(ch), (p > 0) && (ch == 0));
            end
        end
        release_start();
        drain();
        do_stop("full_stop_idle");

        // Sparse mask 2,7,2,7
        pulse_start(8'b1000_0100);
        exp_chan("sparse_ch2a", 3'd2, 1'b0);
        exp_chan("sparse_ch7a", 3'd7, 1'b0);
        exp_chan("sparse_ch2b", 3'd2, 1'b1);
        exp_chan("sparse_ch7b", 3'd7, 1'b0);
        release_start();
        drain();
        do_stop("sparse_stop_idle");

        // Empty mask: start ignored
        pulse_start(8'h00);
        exp_idle("empty_mask_idle", 3);
        release_start();
        drain();

        // Stop in second DRIVE cycle of channel 3
        pulse_start(8'h08);
        exp_seg("stop3_blank", 1'b0, 3'd3, 1'b1, 1'b0, BL);
        exp_seg("stop3_drive", 1'b1, 3'd3, 1'b1, 1'b0, 2);
        release_start();
        drain();
        do_stop("stop3_idle");

        // Start and stop together: stop wins
        pulse_start(8'hFF);
        stop = 1'b1;
        exp_idle("start_stop_idle", 3);
        release_start();
        drain();

        // Mask cleared during DRIVE of channel 1: channel 1 completes, then IDLE
        pulse_start(8'hFF);
        exp_chan("mchg_ch0", 3'd0, 1'b0);
        exp_seg("mchg_ch1_blank", 1'b0, 3'd1, 1'b1, 1'b0, BL);
        exp_seg("mchg_ch1_drive", 1'b1, 3'd1, 1'b1, 1'b0, 1);
        release_start();
        drain();
        chan_mask = 8'h00;
        exp_seg("mchg_ch1_drive_rest", 1'b1, 3'd1, 1'b1, 1'b0, 3);
        exp_idle("mchg_idle", 2);
        drain();

        // Single channel: wrap on every revisit
        pulse_start(8'h01);
        exp_chan("single_ch0a", 3'd0, 1'b0);
        exp_chan("single_ch0b", 3'd0, 1'b1);
        exp_chan("single_ch0c", 3'd0, 1'b1);
        release_start();
        drain();
        do_stop("single_stop_idle");

        // Asynchronous reset in DRIVE of channel 5
        pulse_start(8'h20);
        exp_seg("rst5_blank", 1'b0, 3'd5, 1'b1, 1'b0, BL);
        exp_seg("rst5_drive", 1'b1, 3'd5, 1'b1, 1'b0, 2);
        release_start();
        drain();
        rst_n = 1'b0;
        #1;
        check("async_reset_ch5", {e, a, b, c, busy, wrap}, 6'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        exp_idle("after_async_reset_idle", 3);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got time %0t required finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
